// File: rtl/fgmt_pkg.sv
// Shared fine-grained multithreading definitions: thread state encoding,
// thread-ID / PC-select constants and small helpers for the scheduler.
package fgmt_pkg;

  localparam int THREAD_POOL_SIZE = 4;
  localparam int TID_bits         = 2;

  typedef logic [TID_bits-1:0] tid_t;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    READY    = 2'd1,
    STALLED  = 2'd2
  } thread_state_t;

  localparam tid_t CTID_T0 = 2'd0;
  localparam tid_t CTID_T1 = 2'd1;
  localparam tid_t CTID_T2 = 2'd2;
  localparam tid_t CTID_T3 = 2'd3;

  localparam logic [THREAD_POOL_SIZE-1:0] PC_T0 = 4'b0001;
  localparam logic [THREAD_POOL_SIZE-1:0] PC_T1 = 4'b0010;
  localparam logic [THREAD_POOL_SIZE-1:0] PC_T2 = 4'b0100;
  localparam logic [THREAD_POOL_SIZE-1:0] PC_T3 = 4'b1000;

  // Per-thread transition. Disable dominates; a disabled thread that is
  // enabled becomes READY regardless of a concurrent stall_set. When set and
  // clr coincide the thread simply toggles between READY and STALLED.
  function automatic thread_state_t thread_next(
    input thread_state_t cur,
    input logic          en,
    input logic          set,
    input logic          clr
  );
    thread_state_t nxt;
    nxt = DISABLED;
    if (!en) begin
      nxt = DISABLED;
    end else begin
      case (cur)
        DISABLED: nxt = READY;
        READY:    nxt = set ? STALLED : READY;
        STALLED:  nxt = clr ? READY : STALLED;
        default:  nxt = DISABLED;
      endcase
    end
    return nxt;
  endfunction

  // One-hot PC select for a thread ID.
  function automatic logic [THREAD_POOL_SIZE-1:0] pc_onehot(input tid_t tid);
    logic [THREAD_POOL_SIZE-1:0] pc;
    case (tid)
      CTID_T0: pc = PC_T0;
      CTID_T1: pc = PC_T1;
      CTID_T2: pc = PC_T2;
      CTID_T3: pc = PC_T3;
      default: pc = 4'b0000;
    endcase
    return pc;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin search: starts one past last_tid, wraps 3->0,
// first eligible thread wins. Purely combinational.
module rr_arbiter4
  import fgmt_pkg::*;
(
  input  logic [3:0] eligible,
  input  tid_t       last_tid,
  output tid_t       grant_tid,
  output logic       grant_valid
);

  logic [3:0] rot;     // rot[k] = eligibility of thread last_tid+1+k
  logic [1:0] offset;  // distance of winner from the search start

  // Rotate eligibility so bit 0 is the first thread to consider, then
  // priority-encode the rotated vector and rotate the index back.
  always_comb begin
    rot = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      rot[k] = eligible[last_tid + 2'(k + 1)];
    end
    casez (rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      4'b1000: offset = 2'd3;
      default: offset = 2'd0;
    endcase
    grant_valid = |rot;
    grant_tid   = last_tid + 2'd1 + offset;
  end

endmodule

// File: rtl/thread_scheduler.sv
// Fine-grained multithreading issue scheduler: one small FSM per hardware
// thread, round-robin selection among threads that will be READY after this
// edge, registered issue outputs and a saturating bubble counter.
module thread_scheduler
  import fgmt_pkg::*;
#(
  parameter int NTHR   = THREAD_POOL_SIZE,
  parameter int BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NTHR-1:0]   thread_en,
  input  logic [NTHR-1:0]   stall_set,
  input  logic [NTHR-1:0]   stall_clr,
  output tid_t              ctid,
  output logic [NTHR-1:0]   pc_sel,
  output logic              issue_valid,
  output logic [BCNT_W-1:0] bubble_cnt
);

  thread_state_t state     [NTHR];
  thread_state_t state_nxt [NTHR];
  logic [3:0]    eligible;
  tid_t          last_tid;
  tid_t          grant_tid;
  logic          grant_valid;

  // Next state of every thread; eligibility looks at the post-edge state so
  // a thread stalled on this edge is not picked for the following cycle.
  always_comb begin
    eligible = 4'b0000;
    for (int i = 0; i < NTHR; i++) begin
      state_nxt[i] = thread_next(state[i], thread_en[i], stall_set[i], stall_clr[i]);
      eligible[i]  = (state_nxt[i] == READY);
    end
  end

  rr_arbiter4 u_arb (
    .eligible    (eligible),
    .last_tid    (last_tid),
    .grant_tid   (grant_tid),
    .grant_valid (grant_valid)
  );

  // Thread state registers; reset discards any pending stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHR; i++) begin
        state[i] <= DISABLED;
      end
    end else begin
      for (int i = 0; i < NTHR; i++) begin
        state[i] <= state_nxt[i];
      end
    end
  end

  // Issue outputs, rotation pointer and saturating bubble counter. last_tid
  // resets to 3 so the first search after reset starts at T0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_tid    <= CTID_T3;
      ctid        <= CTID_T0;
      pc_sel      <= '0;
      issue_valid <= 1'b0;
      bubble_cnt  <= '0;
    end else if (grant_valid) begin
      last_tid    <= grant_tid;
      ctid        <= grant_tid;
      pc_sel      <= pc_onehot(grant_tid);
      issue_valid <= 1'b1;
      bubble_cnt  <= bubble_cnt;
    end else begin
      last_tid    <= last_tid;
      ctid        <= ctid;
      pc_sel      <= '0;
      issue_valid <= 1'b0;
      if (bubble_cnt != {BCNT_W{1'b1}}) begin
        bubble_cnt <= bubble_cnt + BCNT_W'(1);
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end

endmodule

// File: tb/tb_thread_scheduler.sv
// Directed bench for thread_scheduler: a table of per-cycle vectors with
// hand-computed issue results, plus hand sequences for asynchronous reset
// and bubble-counter saturation (narrow-counter instance).
module tb_thread_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  thread_en;
  logic [3:0]  stall_set;
  logic [3:0]  stall_clr;
  logic [1:0]  ctid;
  logic [3:0]  pc_sel;
  logic        issue_valid;
  logic [15:0] bubble_cnt;

  logic [3:0]  en2;
  logic [3:0]  zero2;
  logic [1:0]  ctid2;
  logic [3:0]  pc_sel2;
  logic        issue_valid2;
  logic [1:0]  bubble_cnt2;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  set;
    logic [3:0]  clr;
    logic        ev;
    logic [1:0]  ectid;
    logic [15:0] ebcnt;
  } vec_t;

  vec_t vecs[$];

  thread_scheduler #(.NTHR(4), .BCNT_W(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .thread_en   (thread_en),
    .stall_set   (stall_set),
    .stall_clr   (stall_clr),
    .ctid        (ctid),
    .pc_sel      (pc_sel),
    .issue_valid (issue_valid),
    .bubble_cnt  (bubble_cnt)
  );

  // Narrow counter instance with no threads enabled: bubbles every cycle,
  // so saturation at all-ones is reached within a few cycles.
  thread_scheduler #(.NTHR(4), .BCNT_W(2)) dut_sat (
    .clk         (clk),
    .rst_n       (rst_n),
    .thread_en   (en2),
    .stall_set   (zero2),
    .stall_clr   (zero2),
    .ctid        (ctid2),
    .pc_sel      (pc_sel2),
    .issue_valid (issue_valid2),
    .bubble_cnt  (bubble_cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] en, input logic [3:0] set, input logic [3:0] clr,
                     input logic ev, input logic [1:0] ectid, input logic [15:0] ebcnt);
    vec_t v;
    v.en = en; v.set = set; v.clr = clr;
    v.ev = ev; v.ectid = ectid; v.ebcnt = ebcnt;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic ev, input logic [1:0] ectid,
                               input logic [15:0] ebcnt);
    logic [3:0] epc;
    epc = ev ? (4'b0001 << ectid) : 4'b0000;
    check({tag, ".issue_valid"}, {31'd0, issue_valid}, {31'd0, ev});
    check({tag, ".ctid"},        {30'd0, ctid},        {30'd0, ectid});
    check({tag, ".pc_sel"},      {28'd0, pc_sel},      {28'd0, epc});
    check({tag, ".bubble_cnt"},  {16'd0, bubble_cnt},  {16'd0, ebcnt});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n = 1'b0;
    thread_en = 4'h0; stall_set = 4'h0; stall_clr = 4'h0;
    en2 = 4'h0; zero2 = 4'h0;

    // Basic rotation, 8 cycles
    for (int i = 0; i < 8; i++) add(4'hF, 4'h0, 4'h0, 1'b1, 2'(i % 4), 16'd0);
    add(4'hF, 4'h0, 4'h0, 1'b1, 2'd0, 16'd0);
    // T1 stalled right after T0 issued, released four cycles later
    add(4'hF, 4'b0010, 4'h0,    1'b1, 2'd2, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd3, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd0, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd2, 16'd0);
    add(4'hF, 4'h0,    4'b0010, 1'b1, 2'd3, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd0, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd1, 16'd0);
    // Simultaneous set+clr on T2: READY -> STALLED, later STALLED -> READY
    add(4'hF, 4'b0100, 4'b0100, 1'b1, 2'd3, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd0, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd1, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd3, 16'd0);
    add(4'hF, 4'b0100, 4'b0100, 1'b1, 2'd0, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd1, 16'd0);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd2, 16'd0);
    // All stalled: bubbles with ctid holding, then only T3 released
    add(4'hF, 4'hF,    4'h0,    1'b0, 2'd2, 16'd1);
    add(4'hF, 4'h0,    4'h0,    1'b0, 2'd2, 16'd2);
    add(4'hF, 4'h0,    4'h0,    1'b0, 2'd2, 16'd3);
    add(4'hF, 4'h0,    4'b1000, 1'b1, 2'd3, 16'd3);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd3, 16'd3);
    add(4'hF, 4'h0,    4'h0,    1'b1, 2'd3, 16'd3);
    // Disable all, then ignored set in DISABLED and ignored clr in READY
    add(4'h0,    4'h0,    4'h0,    1'b0, 2'd3, 16'd4);
    add(4'b0001, 4'b0001, 4'h0,    1'b1, 2'd0, 16'd4);
    add(4'b0001, 4'h0,    4'b0001, 1'b1, 2'd0, 16'd4);
    add(4'b0011, 4'h0,    4'h0,    1'b1, 2'd1, 16'd4);
    add(4'b0011, 4'b0010, 4'h0,    1'b1, 2'd0, 16'd4);

    // Reset values while rst_n is low
    #12;
    check_outputs("reset", 1'b0, 2'd0, 16'd0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      thread_en = vecs[i].en;
      stall_set = vecs[i].set;
      stall_clr = vecs[i].clr;
      @(posedge clk);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ectid, vecs[i].ebcnt);
      @(negedge clk);
    end

    // Mid-cycle asynchronous reset with a stall pending on T2
    thread_en = 4'hF; stall_set = 4'b0100; stall_clr = 4'h0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 1'b0, 2'd0, 16'd0);
    stall_set = 4'h0;
    thread_en = 4'b0100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outputs("post_rst", 1'b1, 2'd2, 16'd0);

    // Saturation on the 2-bit counter instance
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("sat.reset", {30'd0, bubble_cnt2}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat.cnt%0d", i), {30'd0, bubble_cnt2}, (i < 3) ? i : 3);
      check($sformatf("sat.valid%0d", i), {31'd0, issue_valid2}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/thread_scheduler.md
THREAD_SCHEDULER -- requirements
Module: thread_scheduler

Interface
REQ-001 SHALL have parameter NTHR, default THREAD_POOL_SIZE (4), meaning the hardware thread count; only 4 is supported.
REQ-002 SHALL have parameter BCNT_W, default 16, meaning the width of the bubble counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous assertion, active-low.
REQ-005 SHALL have port thread_en, input, 4, per-thread enable; bit i = thread i.
REQ-006 SHALL have port stall_set, input, 4, per-thread stall request (cache miss, long-latency op); 1-cycle pulse.
REQ-007 SHALL have port stall_clr, input, 4, per-thread stall release (refill done); 1-cycle pulse.
REQ-008 SHALL have port ctid, output, 2, the thread ID issued to fetch (CTID_T0..CTID_T3).
REQ-009 SHALL have port pc_sel, output, 4, the one-hot PC select (PC_T0..PC_T3); 0 when no issue.
REQ-010 SHALL have port issue_valid, output, 1, meaning ctid/pc_sel are valid this cycle; 0 means fetch inserts bubble.
REQ-011 SHALL have port bubble_cnt, output, BCNT_W, the count of cycles with issue_valid=0 since reset.

Function
REQ-012 SHALL hold one per-thread FSM, states DISABLED, READY, STALLED.
REQ-013 Per-thread transitions SHALL be evaluated per edge, priority in this order:
- thread_en=0 -> DISABLED from any state.
- DISABLED with thread_en=1 -> READY.
- READY with stall_set -> STALLED.
- STALLED with stall_clr -> READY.
- stall_set and stall_clr together while READY -> STALLED; while STALLED -> READY.
- stall_set in DISABLED and stall_clr in READY SHALL be ignored.
REQ-014 Eligibility SHALL use next-state, i.e. after applying REQ-013 in the same edge; a thread stalled at edge n is not issued at cycle n+1.
REQ-015 Selection SHALL be round-robin: search starts at (last_tid+1) mod 4, wraps 3->0, first eligible thread wins.
REQ-016 Outputs SHALL be registered, latency 1 cycle: inputs sampled at edge n drive outputs after edge n.
REQ-017 On grant: ctid=winner, pc_sel=one-hot(winner), issue_valid=1, last_tid=winner.
REQ-018 No eligible thread: issue_valid=0, pc_sel=0, ctid and last_tid hold, bubble_cnt increments.
REQ-019 A single eligible thread SHALL be issued every cycle (back-to-back same ctid allowed).
REQ-020 pc_sel SHALL always be one-hot or zero, and consistent with ctid whenever issue_valid=1.
REQ-021 bubble_cnt SHALL saturate at all-ones and never wrap.

Reset
REQ-022 While rst_n=0: all threads DISABLED, last_tid=3, ctid=CTID_T0, pc_sel=0, issue_valid=0, bubble_cnt=0.
REQ-023 Reset asserted mid-operation SHALL clear all state immediately, regardless of clk; pending stalls are discarded.
REQ-024 The first edge after deassertion SHALL evaluate normally; with thread_en=4'hF it issues T0.

Structure
REQ-025 thread_state_t (enum DISABLED/READY/STALLED), TID_bits, THREAD_POOL_SIZE, CTID_T*, PC_T* SHALL reside in the shared fgmt package.
REQ-026 The round-robin search SHALL be one combinational sub-module rr_arbiter4: inputs eligible[3:0] and last_tid; outputs grant_tid and grant_valid.
REQ-027 The per-thread FSMs and counter SHALL be in thread_scheduler; no other sub-modules.

Verification
REQ-028 thread_en=4'hF, no stalls, 8 cycles after reset -> ctid 0,1,2,3,0,1,2,3; issue_valid=1; bubble_cnt=0.
REQ-029 All enabled; stall_set=4'b0010 while last issued T0 -> next issues T2 (T1 skipped); stall_clr=4'b0010 four cycles later -> T1 returns in rotation the cycle after.
REQ-030 stall_set=4'hF in one cycle -> issue_valid=0, pc_sel=0 from the next cycle; bubble_cnt counts 1,2,3...; stall_clr=4'b1000 -> T3 issued every cycle.
REQ-031 stall_set[2] and stall_clr[2] together while T2 READY -> T2 STALLED; repeated while STALLED -> READY.
REQ-032 Force bubble_cnt to 16'hFFFE, then 3 bubble cycles -> holds 16'hFFFF.
REQ-033 rst_n low mid-cycle during issue -> outputs reach reset values immediately; after release with thread_en=4'b0100 -> ctid=2, pc_sel=4'b0100.
